// File: rtl/alt_vipcts131_common_control_packet_decoder.sv
// Avalon-ST VIP packet decoder: forwards video payload, decodes control packets
// into width/height/interlaced, and discards all other packet types.
// Optional dout_sop output is enabled by defining ALT_VIP_DECODER_VIDEO_SOP_EN.
module alt_vipcts131_common_control_packet_decoder #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic                                        din_ready,
  input  logic                                        din_valid,
  input  logic                                        din_sop,
  input  logic                                        din_eop,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
`ifdef ALT_VIP_DECODER_VIDEO_SOP_EN
  output logic                                        dout_sop,
`endif
  output logic                                        end_of_video,
  output logic [15:0]                                 width,
  output logic [15:0]                                 height,
  output logic [3:0]                                  interlaced,
  output logic                                        vip_ctrl_valid
);

  localparam int unsigned NIBBLES = 9;

  typedef enum logic [1:0] {IDLE, VIDEO, CTRL, DISCARD} state_t;

  state_t                    state, state_next;
  logic                      accept, header, payload, commit;
  logic [3:0]                pkt_type;
  logic [3:0]                count, count_next;
  logic [NIBBLES-1:0][3:0]   shadow, shadow_next;

  assign accept   = din_valid & din_ready;
  assign header   = accept & din_sop;
  assign payload  = accept & ~din_sop;
  assign pkt_type = din_data[3:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A sop beat is decoded as a header in every state, abandoning any packet in flight.
  always_comb begin
    state_next = state;
    if (header) begin
      if (din_eop)                 state_next = IDLE;
      else if (pkt_type == 4'h0)   state_next = VIDEO;
      else if (pkt_type == 4'hF)   state_next = CTRL;
      else                         state_next = DISCARD;
    end else if (payload && din_eop) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    din_ready    = 1'b1;
    dout_valid   = 1'b0;
    end_of_video = 1'b0;
    if (state == VIDEO) begin
      din_ready    = dout_ready;
      dout_valid   = din_valid & ~din_sop;
      end_of_video = din_valid & din_eop & ~din_sop;
    end
  end

  assign dout_data = din_data;

  // Symbol s of the current beat lands in nibble slot count+s; slots past the last are dropped.
  always_comb begin
    shadow_next = shadow;
    for (int unsigned k = 0; k < NIBBLES; k++)
      for (int unsigned s = 0; s < SYMBOLS_PER_BEAT; s++)
        if (32'(count) + s == k)
          shadow_next[k] = din_data[s*BITS_PER_SYMBOL +: 4];
    if (32'(count) + SYMBOLS_PER_BEAT >= NIBBLES) count_next = 4'(NIBBLES);
    else                                          count_next = count + 4'(SYMBOLS_PER_BEAT);
  end

  assign commit = (state == CTRL) & payload & din_eop & (count_next == 4'(NIBBLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= '0;
      shadow         <= '0;
      width          <= '0;
      height         <= '0;
      interlaced     <= '0;
      vip_ctrl_valid <= 1'b0;
    end else begin
      vip_ctrl_valid <= commit;
      if (header) begin
        count <= '0;
      end else if (state == CTRL && payload) begin
        count  <= count_next;
        shadow <= shadow_next;
      end
      if (commit) begin
        width      <= {shadow_next[0], shadow_next[1], shadow_next[2], shadow_next[3]};
        height     <= {shadow_next[4], shadow_next[5], shadow_next[6], shadow_next[7]};
        interlaced <= shadow_next[8];
      end
    end
  end

`ifdef ALT_VIP_DECODER_VIDEO_SOP_EN
  logic sop_pending;

  always_ff @(posedge clk) begin
    if (rst)                          sop_pending <= 1'b0;
    else if (header)                  sop_pending <= (pkt_type == 4'h0) & ~din_eop;
    else if (dout_valid & dout_ready) sop_pending <= 1'b0;
  end

  assign dout_sop = sop_pending & dout_valid;
`endif

endmodule

// File: tb/tb_alt_vipcts131_common_control_packet_decoder.sv
// Randomized bench for the VIP packet decoder, checked against a packet-level
// reference model (nibble queue, expected video beat queue).
module tb_alt_vipcts131_common_control_packet_decoder;

  localparam int BPS = 8;
  localparam int SPB = 3;
  localparam int DW  = BPS * SPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_ready, din_valid, din_sop, din_eop;
  logic [DW-1:0] din_data;
  logic          dout_ready, dout_valid, end_of_video, vip_ctrl_valid;
  logic [DW-1:0] dout_data;
  logic [15:0]   width, height;
  logic [3:0]    interlaced;
`ifdef ALT_VIP_DECODER_VIDEO_SOP_EN
  logic          dout_sop;
`endif

  alt_vipcts131_common_control_packet_decoder #(
    .BITS_PER_SYMBOL (BPS),
    .SYMBOLS_PER_BEAT(SPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din_ready     (din_ready),
    .din_valid     (din_valid),
    .din_sop       (din_sop),
    .din_eop       (din_eop),
    .din_data      (din_data),
    .dout_ready    (dout_ready),
    .dout_valid    (dout_valid),
    .dout_data     (dout_data),
`ifdef ALT_VIP_DECODER_VIDEO_SOP_EN
    .dout_sop      (dout_sop),
`endif
    .end_of_video  (end_of_video),
    .width         (width),
    .height        (height),
    .interlaced    (interlaced),
    .vip_ctrl_valid(vip_ctrl_valid)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_VIDEO, M_CTRL, M_DISC} mode_t;
  typedef struct {logic [DW-1:0] data; bit last;} vbeat_t;

  mode_t         mode;
  int unsigned   m_width, m_height, m_int;
  bit            m_strobe, first_pending;
  int unsigned   nibs[$];
  vbeat_t        exp_q[$];
  logic [DW-1:0] pkt[$];
  int            n_vec, n_err;
  bit            gap_en, rand_ready;
  int            hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; m_width = 0; m_height = 0; m_int = 0;
    m_strobe = 0; first_pending = 0; nibs.delete();
  endtask

  // One clock: compare at negedge, then advance the model with what the edge accepted.
  task automatic step(output bit acc);
    bit exp_ready, exp_dv, dacc;
    int unsigned nib;
    vbeat_t vb;
    @(negedge clk);
    exp_ready = (mode == M_VIDEO) ? dout_ready : 1'b1;
    exp_dv    = (mode == M_VIDEO) && din_valid && !din_sop;
    check_eq("din_ready", 32'(din_ready), 32'(exp_ready));
    check_eq("dout_valid", 32'(dout_valid), 32'(exp_dv));
    check_eq("end_of_video", 32'(end_of_video), 32'(exp_dv && din_eop));
    dacc = exp_dv && dout_ready;
    if (dacc) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL video_beat: got unexpected beat 0x%0h expected none", dout_data);
      end else begin
        vb = exp_q.pop_front();
        check_eq("dout_data", 32'(dout_data), 32'(vb.data));
        check_eq("eov_last", 32'(end_of_video), 32'(vb.last));
      end
    end
`ifdef ALT_VIP_DECODER_VIDEO_SOP_EN
    check_eq("dout_sop", 32'(dout_sop), 32'(exp_dv && first_pending));
`endif
    check_eq("width", 32'(width), m_width);
    check_eq("height", 32'(height), m_height);
    check_eq("interlaced", 32'(interlaced), m_int);
    check_eq("vip_ctrl_valid", 32'(vip_ctrl_valid), 32'(m_strobe));
    acc = din_valid && exp_ready && !rst;
    @(posedge clk);
    m_strobe = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (dacc) first_pending = 0;
      if (acc && din_sop) begin
        nibs.delete();
        if (din_eop)                   mode = M_IDLE;
        else if (din_data[3:0] == 4'h0) mode = M_VIDEO;
        else if (din_data[3:0] == 4'hF) mode = M_CTRL;
        else                           mode = M_DISC;
        first_pending = (mode == M_VIDEO);
      end else if (acc) begin
        if (mode == M_CTRL) begin
          for (int s = 0; s < SPB; s++) begin
            nib = 32'((din_data >> (BPS*s)) & DW'(15));
            nibs.push_back(nib);
          end
          if (din_eop && nibs.size() >= 9) begin
            m_width  = (nibs[0] << 12) | (nibs[1] << 8) | (nibs[2] << 4) | nibs[3];
            m_height = (nibs[4] << 12) | (nibs[5] << 8) | (nibs[6] << 4) | nibs[7];
            m_int    = nibs[8];
            m_strobe = 1;
          end
        end
        if (din_eop) mode = M_IDLE;
      end
    end
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input bit sop, input bit eop);
    bit acc, done;
    int tries;
    done = 0; tries = 0;
    while (!done) begin
      if (hold > 0) begin dout_ready = 1'b0; hold--; end
      else dout_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (gap_en && $urandom_range(0, 3) == 0) begin
        din_valid = 1'b0; din_data = DW'($urandom);
        din_sop = 1'($urandom_range(0, 1)); din_eop = 1'($urandom_range(0, 1));
        step(acc);
      end else begin
        din_valid = 1'b1; din_data = data; din_sop = sop; din_eop = eop;
        step(acc);
        if (acc) done = 1;
      end
      tries++;
      if (!done && tries > 200) begin
        n_vec++; n_err++;
        $display("FAIL beat_timeout: got no acceptance in %0d cycles expected acceptance", tries);
        done = 1;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b0;
      dout_ready = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
      step(acc);
    end
  endtask

  // Sends header hdr then the beats in pkt; video payload is queued as expected output.
  task automatic send_pkt(input logic [DW-1:0] hdr, input bit end_eop, input int hold_at);
    vbeat_t vb;
    int n;
    n = pkt.size();
    if (hdr[3:0] == 4'h0) begin
      for (int i = 0; i < n; i++) begin
        vb.data = pkt[i];
        vb.last = end_eop && (i == n - 1);
        exp_q.push_back(vb);
      end
    end
    send_beat(hdr, 1'b1, end_eop && n == 0);
    for (int i = 0; i < n; i++) begin
      if (i == hold_at) hold = 3;
      send_beat(pkt[i], 1'b0, end_eop && (i == n - 1));
    end
    pkt.delete();
  endtask

  task automatic rand_pkt();
    int r, nb;
    logic [3:0] t;
    r = int'($urandom_range(0, 9));
    if (r <= 3)      begin t = 4'h0; nb = int'($urandom_range(0, 6)); end
    else if (r <= 6) begin t = 4'hF; nb = int'($urandom_range(0, 5)); end
    else if (r <= 8) begin t = 4'(1 + $urandom_range(0, 13)); nb = int'($urandom_range(0, 4)); end
    else begin
      send_beat(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      return;
    end
    for (int i = 0; i < nb; i++) pkt.push_back(DW'($urandom));
    send_pkt((DW'($urandom) & ~DW'(15)) | DW'(t), 1'b1, -1);
  endtask

  initial begin
    bit acc;
    n_vec = 0; n_err = 0; hold = 0; gap_en = 0; rand_ready = 0;
    rst = 1'b1; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_data = '0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_eq("rst_width", 32'(width), 32'd0);
    check_eq("rst_height", 32'(height), 32'd0);
    check_eq("rst_interlaced", 32'(interlaced), 32'd0);
    check_eq("rst_strobe", 32'(vip_ctrl_valid), 32'd0);
    check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
    check_eq("rst_din_ready", 32'(din_ready), 32'd1);

    // Control packet 640x480, interlace 3
    pkt = '{24'h080200, 24'h010000, 24'h03000E};
    send_pkt(24'h00000F, 1'b1, -1);
    check_eq("tp_strobe", 32'(vip_ctrl_valid), 32'd1);
    check_eq("tp_width", 32'(width), 32'd640);
    check_eq("tp_height", 32'(height), 32'd480);
    check_eq("tp_interlaced", 32'(interlaced), 32'd3);
    idle(1);
    check_eq("tp_strobe_once", 32'(vip_ctrl_valid), 32'd0);

    // Video packet, then the same with a 3-cycle stall
    pkt = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    send_pkt(24'h000000, 1'b1, -1);
    pkt = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    send_pkt(24'h000000, 1'b1, 2);

    // Short control: must not disturb committed values
    pkt = '{24'h050505};
    send_pkt(24'h00000F, 1'b1, -1);
    idle(1);
    check_eq("short_width", 32'(width), 32'd640);
    check_eq("short_height", 32'(height), 32'd480);
    check_eq("short_interlaced", 32'(interlaced), 32'd3);

    // User packet then video
    pkt = '{24'hABCDEF, 24'h123456, 24'h00FF00};
    send_pkt(24'h000005, 1'b1, -1);
    pkt = '{24'h0A0B0C, 24'hFFFFFF};
    send_pkt(24'h000000, 1'b1, -1);

    // Back-to-back commits, then a video packet abandoned by a mid-packet header
    pkt = '{24'h010203, 24'h040506, 24'h070809};
    send_pkt(24'h00000F, 1'b1, -1);
    pkt = '{24'h0F0E0D, 24'h0C0B0A, 24'h090807};
    send_pkt(24'h00000F, 1'b1, -1);
    pkt = '{24'h777777, 24'h888888};
    send_pkt(24'h000000, 1'b0, -1);
    pkt = '{24'h000102, 24'h030405, 24'h060708};
    send_pkt(24'h00000F, 1'b1, -1);

    // Reset after the second control beat, with a header beat presented under reset
    pkt = '{24'h0A0A0A, 24'h0B0B0B};
    send_pkt(24'h00000F, 1'b0, -1);
    rst = 1'b1; din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = '0; dout_ready = 1'b1;
    step(acc);
    rst = 1'b0; din_valid = 1'b0;
    check_eq("mid_rst_width", 32'(width), 32'd0);
    check_eq("mid_rst_height", 32'(height), 32'd0);
    check_eq("mid_rst_interlaced", 32'(interlaced), 32'd0);
    check_eq("mid_rst_strobe", 32'(vip_ctrl_valid), 32'd0);
    pkt = '{24'h135790, 24'h246802, 24'h9ABCDE};
    send_pkt(24'h000000, 1'b1, -1);

    // Randomized traffic with gaps and backpressure
    gap_en = 1; rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      rand_pkt();
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    gap_en = 0; rand_ready = 0;
    idle(2);
    check_eq("video_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion expected completion by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alt_vipcts131_common_control_packet_decoder.md
# alt_vipcts131_common_control_packet_decoder

Avalon-ST VIP packet decoder at the input of a VIP-style processing block. It is the receive-side counterpart of the control packet encoder. It classifies each incoming packet by the type nibble of its header beat. Video packet payload is passed to the user algorithm with an end-of-video marker. Control packet payload is decoded into width, height and interlace fields, and a one-cycle update strobe is raised. All other packet types are consumed and discarded.

## Interface
- BITS_PER_SYMBOL, 8, bits per symbol; nibble carried in bits [3:0] of each symbol
- SYMBOLS_PER_BEAT, 3, symbols per beat; legal range 1..9
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- din_ready  out  1  Avalon-ST sink ready
- din_valid  in  1  sink valid
- din_sop  in  1  sink start of packet
- din_eop  in  1  sink end of packet
- din_data  in  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  sink data
- dout_ready  in  1  user algorithm ready
- dout_valid  out  1  video payload beat valid
- dout_data  out  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  video payload data
- end_of_video  out  1  qualifies the last video beat (dout_valid & end_of_video)
- width  out  16  last committed frame width
- height  out  16  last committed frame height
- interlaced  out  4  last committed interlace nibble
- vip_ctrl_valid  out  1  one-cycle strobe; new width/height/interlaced values are present

## Operation
- States: IDLE, VIDEO, CTRL, DISCARD. Reset state is IDLE.
- A beat is accepted when din_valid & din_ready.
- IDLE: din_ready=1.
  - Accepted sop beat = header; type = din_data[3:0]. It is never forwarded.
  - Type 0x0 -> VIDEO. Type 0xF -> CTRL, with nibble counter cleared. Any other type -> DISCARD.
  - If the header beat also carries eop, stay in IDLE.
  - An accepted non-sop beat in IDLE is dropped.
- VIDEO: pass-through.
  - din_ready = dout_ready.
  - dout_valid = din_valid & ~din_sop.
  - dout_data = din_data.
  - end_of_video = din_valid & din_eop & ~din_sop.
  - Accepted eop -> IDLE.
- CTRL: din_ready=1.
  - Symbol s of the beat is nibble index k = count + s. Capture bits [3:0] of symbol s into a shadow register.
  - Order for k=0..8: w3, w2, w1, w0, h3, h2, h1, h0, int. Nibbles with k≥9 are ignored.
  - Count advances by SYMBOLS_PER_BEAT and saturates at 9.
  - On accepted eop with count≥9 after that beat: commit the shadow registers to width/height/interlaced and pulse vip_ctrl_valid. Then go to IDLE.
  - On eop with count<9: no commit, no strobe. Then go to IDLE.
- DISCARD: din_ready=1. Accepted eop -> IDLE.
- Mid-packet sop (in VIDEO/CTRL/DISCARD):
  - The beat is treated as a new header and decoded as in IDLE.
  - The packet in progress is abandoned: no commit, no end_of_video.
  - In VIDEO, din_ready still equals dout_ready for this beat.
- Outputs width/height/interlaced change only on commit, so partial packets are never visible.
- dout_valid=0 and end_of_video=0 in every state except VIDEO.

## Timing
- Reset (synchronous, one clk edge with rst=1):
  - state=IDLE, counter=0, shadow registers=0.
  - width=0, height=0, interlaced=0, vip_ctrl_valid=0.
  - dout_valid=0 and end_of_video=0 as a consequence of state.
  - rst overrides any simultaneous beat.
- Video path: zero latency, purely combinational from din to dout. Backpressure propagates combinationally.
- Control commit: width/height/interlaced update on the clock edge that accepts the control eop beat. vip_ctrl_valid is high for exactly the following cycle.
- Back-to-back packets: a header may be accepted in the cycle immediately after any eop. There are no bubbles.
- A control commit followed immediately by another control commit produces two separate one-cycle strobes.

## Configuration
- ALT_VIP_DECODER_VIDEO_SOP_EN defined:
  - Adds output port dout_sop (1 bit).
  - dout_sop is asserted with the first forwarded beat of each video packet, i.e. the first dout_valid beat after the video header.
  - The flag is cleared once that beat is accepted and reset to 0.
- Not defined: port and flag absent. Behaviour is otherwise identical.

## Test plan
- Control packet, SYMBOLS_PER_BEAT=3:
  - Stimulus: 0x00000F sop, 0x080200, 0x010000, 0x03000E eop.
  - Response: width=640, height=480, interlaced=3. vip_ctrl_valid high one cycle after the eop edge. dout_valid never asserted.
- Video packet:
  - Stimulus: header 0x000000 sop, then payload 0x111111, 0x222222, 0x333333, 0x444444 (eop).
  - Response: exactly 4 dout beats with those values. end_of_video on 0x444444 only. Header not forwarded.
- Backpressure:
  - Stimulus: same video packet, dout_ready low for 3 cycles mid-packet.
  - Response: din_ready low in those cycles, no beat lost or duplicated, order preserved.
- Short control:
  - Stimulus: after the first scenario, header 0xF then one beat 0x050505 with eop.
  - Response: width/height/interlaced remain 640/480/3, no strobe.
- User packet:
  - Stimulus: header type 0x5, 3 beats, eop.
  - Response: din_ready=1 throughout, no dout_valid, no strobe. A following video packet is forwarded normally.
- Reset mid-operation:
  - Stimulus: rst for 1 cycle after the second beat of a control packet.
  - Response: all outputs 0, then a fresh video packet passes unchanged.
  - With ALT_VIP_DECODER_VIDEO_SOP_EN: dout_sop on its first beat only.
